// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the MIPS ALU control / multiply-divide block.
// Holds the ALUOp classes, funct codes, ALU control words, the sequencer
// state enum, and helpers that classify funct codes.
package mips_ctrl_pkg;

  // ALUOp classes from the main control FSM
  localparam logic [2:0] ALUOP_ADD   = 3'b000;
  localparam logic [2:0] ALUOP_SUB   = 3'b001;
  localparam logic [2:0] ALUOP_RTYPE = 3'b010;
  localparam logic [2:0] ALUOP_OR    = 3'b011;
  localparam logic [2:0] ALUOP_AND   = 3'b100;
  localparam logic [2:0] ALUOP_SLT   = 3'b101;
  localparam logic [2:0] ALUOP_XOR   = 3'b110;
  localparam logic [2:0] ALUOP_ADD2  = 3'b111;

  // R-type funct codes
  localparam logic [5:0] F_SLL   = 6'b000000;
  localparam logic [5:0] F_SRL   = 6'b000010;
  localparam logic [5:0] F_SRA   = 6'b000011;
  localparam logic [5:0] F_MFHI  = 6'b010000;
  localparam logic [5:0] F_MFLO  = 6'b010010;
  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_DIVU  = 6'b011011;
  localparam logic [5:0] F_ADD   = 6'b100000;
  localparam logic [5:0] F_ADDU  = 6'b100001;
  localparam logic [5:0] F_SUB   = 6'b100010;
  localparam logic [5:0] F_SUBU  = 6'b100011;
  localparam logic [5:0] F_AND   = 6'b100100;
  localparam logic [5:0] F_OR    = 6'b100101;
  localparam logic [5:0] F_XOR   = 6'b100110;
  localparam logic [5:0] F_NOR   = 6'b100111;
  localparam logic [5:0] F_SLT   = 6'b101010;
  localparam logic [5:0] F_SLTU  = 6'b101011;

  // ALU control words
  typedef enum logic [3:0] {
    CNT_AND  = 4'b0000,
    CNT_OR   = 4'b0001,
    CNT_ADD  = 4'b0010,
    CNT_XOR  = 4'b0011,
    CNT_SUB  = 4'b0110,
    CNT_SLT  = 4'b0111,
    CNT_SLL  = 4'b1000,
    CNT_SRL  = 4'b1001,
    CNT_SRA  = 4'b1010,
    CNT_SLTU = 4'b1011,
    CNT_NOR  = 4'b1100
  } alu_cnt_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_FIX  = 2'd3
  } mdu_state_t;

  // MULT/MULTU/DIV/DIVU all share the 0110xx pattern
  function automatic logic is_mdu_start(input logic [5:0] f);
    return f[5:2] == 4'b0110;
  endfunction

  // Anything that touches HI/LO and therefore must wait on the sequencer
  function automatic logic is_mdu_funct(input logic [5:0] f);
    return is_mdu_start(f) || (f == F_MFHI) || (f == F_MFLO);
  endfunction

endpackage

// File: rtl/mdu_iter.sv
// Iterative multiply/divide datapath.
// load      : latch operand magnitudes (signed ops) or raw values, and signs
// is_div    : 1 = restoring divide, 0 = shift-add multiply (sampled on load)
// is_signed : operands are two's complement (sampled on load)
// step      : perform one iteration (one product/quotient bit)
// a, b      : rs / rt operands
// res_hi/lo : sign-corrected result, valid once WIDTH steps have run
module mdu_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             is_div,
  input  logic             is_signed,
  input  logic             step,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] res_hi,
  output logic [WIDTH-1:0] res_lo
);

  // acc holds {partial product, multiplier} for MUL and {remainder, dividend/quotient} for DIV
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   dvs_q, dvs_d;      // multiplicand or divisor magnitude
  logic               div_q, div_d;
  logic               neg_q, neg_d;      // negate product / quotient
  logic               rneg_q, rneg_d;    // negate remainder (dividend sign)
  logic               zero_q, zero_d;    // divide by zero: force quotient to all ones

  logic [WIDTH-1:0]   abs_a, abs_b;
  logic [WIDTH:0]     sum, shifted, diff;
  logic               ge;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   quo, rem;

  always_comb begin
    abs_a   = (is_signed && a[WIDTH-1]) ? -a : a;
    abs_b   = (is_signed && b[WIDTH-1]) ? -b : b;
    sum     = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, dvs_q} : '0);
    shifted = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    diff    = shifted - {1'b0, dvs_q};
    ge      = shifted >= {1'b0, dvs_q};

    acc_d  = acc_q;
    dvs_d  = dvs_q;
    div_d  = div_q;
    neg_d  = neg_q;
    rneg_d = rneg_q;
    zero_d = zero_q;
    if (load) begin
      acc_d  = {{WIDTH{1'b0}}, is_div ? abs_a : abs_b};
      dvs_d  = is_div ? abs_b : abs_a;
      div_d  = is_div;
      neg_d  = is_signed && (a[WIDTH-1] ^ b[WIDTH-1]);
      rneg_d = is_signed && a[WIDTH-1];
      zero_d = is_div && (b == '0);
    end else if (step) begin
      if (div_q)
        // Remainder never exceeds the divisor, so WIDTH bits always hold it.
        acc_d = {ge ? diff[WIDTH-1:0] : shifted[WIDTH-1:0], acc_q[WIDTH-2:0], ge};
      else
        acc_d = {sum, acc_q[WIDTH-1:1]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q  <= '0;
      dvs_q  <= '0;
      div_q  <= 1'b0;
      neg_q  <= 1'b0;
      rneg_q <= 1'b0;
      zero_q <= 1'b0;
    end else begin
      acc_q  <= acc_d;
      dvs_q  <= dvs_d;
      div_q  <= div_d;
      neg_q  <= neg_d;
      rneg_q <= rneg_d;
      zero_q <= zero_d;
    end
  end

  // Sign fix-up. With a zero divisor every trial subtract succeeds, so the
  // remainder ends as |dividend|; re-signing it restores the original src_a.
  always_comb begin
    prod = neg_q ? -acc_q : acc_q;
    quo  = acc_q[WIDTH-1:0];
    rem  = acc_q[2*WIDTH-1:WIDTH];
    if (div_q) begin
      res_lo = zero_q ? '1 : (neg_q ? -quo : quo);
      res_hi = rneg_q ? -rem : rem;
    end else begin
      res_lo = prod[WIDTH-1:0];
      res_hi = prod[2*WIDTH-1:WIDTH];
    end
  end

endmodule

// File: rtl/alu_control_mdu.sv
// ALU control decode plus iterative MULT/MULTU/DIV/DIVU sequencer with HI/LO.
// ALUOp/funct -> ALUCnt, illegal   : combinational decode
// issue, src_a, src_b              : start a mult/div (or qualify mfhi/mflo)
// hi, lo                           : HI/LO registers
// busy                             : sequencer not idle
// stall                            : HI/LO consumer issued while busy
// done                             : one-cycle pulse after HI/LO are written
// div_zero                         : sticky divide-by-zero flag
module alu_control_mdu
  import mips_ctrl_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int ALUOP_W = 3,
  parameter int CNT_W   = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [ALUOP_W-1:0] ALUOp,
  input  logic [5:0]         funct,
  input  logic               issue,
  input  logic [WIDTH-1:0]   src_a,
  input  logic [WIDTH-1:0]   src_b,
  output logic [CNT_W-1:0]   ALUCnt,
  output logic               illegal,
  output logic [WIDTH-1:0]   hi,
  output logic [WIDTH-1:0]   lo,
  output logic               busy,
  output logic               stall,
  output logic               done,
  output logic               div_zero
);

  localparam int CW = $clog2(WIDTH) + 1;

  mdu_state_t       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
  logic             done_q, done_d;
  logic             dz_q, dz_d;

  logic             rtype, start, load, step;
  logic [WIDTH-1:0] res_hi, res_lo;
  alu_cnt_t         cnt_w;

  // ---------------- decode ----------------
  always_comb begin
    cnt_w   = CNT_ADD;
    illegal = 1'b0;
    case (ALUOp)
      ALUOP_W'(ALUOP_ADD):  cnt_w = CNT_ADD;
      ALUOP_W'(ALUOP_SUB):  cnt_w = CNT_SUB;
      ALUOP_W'(ALUOP_OR):   cnt_w = CNT_OR;
      ALUOP_W'(ALUOP_AND):  cnt_w = CNT_AND;
      ALUOP_W'(ALUOP_SLT):  cnt_w = CNT_SLT;
      ALUOP_W'(ALUOP_XOR):  cnt_w = CNT_XOR;
      ALUOP_W'(ALUOP_ADD2): cnt_w = CNT_ADD;
      ALUOP_W'(ALUOP_RTYPE): begin
        case (funct)
          F_ADD, F_ADDU: cnt_w = CNT_ADD;
          F_SUB, F_SUBU: cnt_w = CNT_SUB;
          F_AND:         cnt_w = CNT_AND;
          F_OR:          cnt_w = CNT_OR;
          F_XOR:         cnt_w = CNT_XOR;
          F_NOR:         cnt_w = CNT_NOR;
          F_SLT:         cnt_w = CNT_SLT;
          F_SLTU:        cnt_w = CNT_SLTU;
          F_SLL:         cnt_w = CNT_SLL;
          F_SRL:         cnt_w = CNT_SRL;
          F_SRA:         cnt_w = CNT_SRA;
          default: begin
            // HI/LO ops pass through as ADD; everything else is undefined
            cnt_w   = CNT_ADD;
            illegal = !is_mdu_funct(funct);
          end
        endcase
      end
      default: cnt_w = CNT_ADD;
    endcase
  end

  assign ALUCnt = CNT_W'(cnt_w);

  // ---------------- sequencer ----------------
  assign rtype = (ALUOp == ALUOP_W'(ALUOP_RTYPE));
  assign start = issue && rtype && is_mdu_start(funct) && (state_q == S_IDLE);
  // FIX counts as busy, so an issue there stalls too
  assign stall = issue && rtype && is_mdu_funct(funct) && (state_q != S_IDLE);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = 1'b0;
    dz_d    = dz_q;
    load    = 1'b0;
    step    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          load    = 1'b1;
          cnt_d   = '0;
          dz_d    = funct[1] && (src_b == '0);
          state_d = funct[1] ? S_DIV : S_MUL;
        end
      end
      S_MUL, S_DIV: begin
        step  = 1'b1;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(WIDTH - 1))
          state_d = S_FIX;
      end
      S_FIX: begin
        hi_d    = res_hi;
        lo_d    = res_lo;
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
      dz_q    <= dz_d;
    end
  end

  mdu_iter #(.WIDTH(WIDTH)) u_iter (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (load),
    .is_div    (funct[1]),
    .is_signed (!funct[0]),
    .step      (step),
    .a         (src_a),
    .b         (src_b),
    .res_hi    (res_hi),
    .res_lo    (res_lo)
  );

  assign hi       = hi_q;
  assign lo       = lo_q;
  assign busy     = (state_q != S_IDLE);
  assign done     = done_q;
  assign div_zero = dz_q;

endmodule
